// File: rtl/blob_frame_sequencer.sv
// ============================================================================
//  blob_frame_sequencer : frame-aligned capture / label / publish scheduler
//  Revision 1.0
// ============================================================================
`default_nettype none

module blob_frame_sequencer #(
  parameter int FRAME_W        = 16,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_VGA_VSYNC,
  input  logic               i_oPROC_CCD,
  input  logic               i_enable,
  input  logic               i_grayscale_done,
  input  logic               i_blob_end,
  output logic               o_grayscale_start,
  output logic               o_blob_start,
  output logic               o_result_valid,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_error,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC1 = 3'd1,
    S_GRAY  = 3'd2,
    S_SYNC2 = 3'd3,
    S_BLOB  = 3'd4,
    S_SYNC3 = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int          TW      = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT_FRAMES - 1);

  state_t        r_state;
  logic          r_vs_d;
  logic [TW-1:0] r_tcnt;
  logic          w_bnd;
  logic          w_run;

  assign w_bnd   = i_VGA_VSYNC & ~r_vs_d;
  assign w_run   = i_oPROC_CCD & i_enable;
  assign o_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // vs_d resets high so a VSYNC already high is not seen as a boundary
      r_state           <= S_IDLE;
      r_vs_d            <= 1'b1;
      r_tcnt            <= '0;
      o_grayscale_start <= 1'b0;
      o_blob_start      <= 1'b0;
      o_result_valid    <= 1'b0;
      o_frame_cnt       <= '0;
      o_error           <= 1'b0;
    end else begin
      r_vs_d       <= i_VGA_VSYNC;
      o_blob_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_run) r_state <= S_SYNC1;
        end
        S_SYNC1: begin
          if (!w_run) begin
            r_state <= S_IDLE;
          end else if (w_bnd) begin
            r_state           <= S_GRAY;
            o_grayscale_start <= 1'b1;
            r_tcnt            <= '0;
          end
        end
        S_GRAY: begin
          if (!w_run) begin
            r_state           <= S_IDLE;
            o_grayscale_start <= 1'b0;
          end else if (i_grayscale_done && w_bnd) begin
            r_state           <= S_BLOB;
            o_grayscale_start <= 1'b0;
            o_blob_start      <= 1'b1;
            o_result_valid    <= 1'b0;
            r_tcnt            <= '0;
          end else if (i_grayscale_done) begin
            r_state <= S_SYNC2;
          end else if (w_bnd) begin
            if (r_tcnt == C_TLAST) begin
              r_state           <= S_ERR;
              o_grayscale_start <= 1'b0;
              o_error           <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        S_SYNC2: begin
          if (!w_run) begin
            r_state           <= S_IDLE;
            o_grayscale_start <= 1'b0;
          end else if (w_bnd) begin
            r_state           <= S_BLOB;
            o_grayscale_start <= 1'b0;
            o_blob_start      <= 1'b1;
            o_result_valid    <= 1'b0;
            r_tcnt            <= '0;
          end
        end
        S_BLOB: begin
          // the blob engine cannot be cancelled, so run is only consulted at publish
          if (i_blob_end && w_bnd) begin
            o_result_valid    <= 1'b1;
            o_frame_cnt       <= o_frame_cnt + 1'b1;
            r_tcnt            <= '0;
            r_state           <= w_run ? S_GRAY : S_IDLE;
            o_grayscale_start <= w_run;
          end else if (i_blob_end) begin
            r_state <= S_SYNC3;
          end else if (w_bnd) begin
            if (r_tcnt == C_TLAST) begin
              r_state <= S_ERR;
              o_error <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        S_SYNC3: begin
          if (w_bnd) begin
            o_result_valid    <= 1'b1;
            o_frame_cnt       <= o_frame_cnt + 1'b1;
            r_tcnt            <= '0;
            r_state           <= w_run ? S_GRAY : S_IDLE;
            o_grayscale_start <= w_run;
          end
        end
        S_ERR: begin
          o_grayscale_start <= 1'b0;
          o_error           <= 1'b1;
          if (!i_enable) begin
            r_state <= S_IDLE;
            o_error <= 1'b0;
          end
        end
        default: begin
          r_state           <= S_IDLE;
          o_grayscale_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blob_frame_sequencer.sv
// ============================================================================
//  tb_blob_frame_sequencer : directed bench with frame-count scoreboard
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_blob_frame_sequencer;

  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          ccd;
  logic          en;
  logic          gdone;
  logic          bend;
  logic          gstart;
  logic          bstart;
  logic          rvalid;
  logic [FW-1:0] fcnt;
  logic          err;
  logic [2:0]    st;

  int nerr    = 0;
  int nchecks = 0;
  int bs_seen = 0;
  int bs_exp  = 0;
  logic [FW-1:0] exp_cnt = '0;
  logic [FW-1:0] prev_cnt = '0;
  logic [FW-1:0] q[$];

  always #5 clk = ~clk;

  blob_frame_sequencer #(.FRAME_W(FW), .TIMEOUT_FRAMES(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_VGA_VSYNC      (vsync),
    .i_oPROC_CCD      (ccd),
    .i_enable         (en),
    .i_grayscale_done (gdone),
    .i_blob_end       (bend),
    .o_grayscale_start(gstart),
    .o_blob_start     (bstart),
    .o_result_valid   (rvalid),
    .o_frame_cnt      (fcnt),
    .o_error          (err),
    .o_state          (st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Boundary is sampled on the second edge; optional completion pulses coincide with it
  task automatic boundary(input logic d, input logic e);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    gdone = d;
    bend  = e;
    tick();
    gdone = 1'b0;
    bend  = 1'b0;
  endtask

  task automatic pulse_done();
    gdone = 1'b1;
    tick();
    gdone = 1'b0;
  endtask

  task automatic pulse_end();
    bend = 1'b1;
    tick();
    bend = 1'b0;
  endtask

  task automatic expect_publish();
    exp_cnt = exp_cnt + 1'b1;
    q.push_back(exp_cnt);
  endtask

  // Scoreboard: every frame-count change must match the next queued expectation
  always @(posedge clk) begin
    #1;
    if (bstart === 1'b1) bs_seen++;
    if (fcnt !== prev_cnt) begin
      if (q.size() == 0) begin
        chk("unexpected_cnt_change", 32'(fcnt), 32'(prev_cnt));
      end else begin
        chk("sb_frame_cnt", 32'(fcnt), 32'(q.pop_front()));
      end
    end
    prev_cnt = fcnt;
  end

  initial begin
    rst = 1'b1; vsync = 1'b1; ccd = 1'b0; en = 1'b0; gdone = 1'b0; bend = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(st), 0);
    chk("rst_gstart", 32'(gstart), 0);
    chk("rst_bstart", 32'(bstart), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_cnt", 32'(fcnt), 0);
    chk("rst_err", 32'(err), 0);

    // Nominal frame
    ccd = 1'b1; en = 1'b1;
    tick();
    chk("nom_sync1", 32'(st), 1);
    boundary(1'b0, 1'b0);
    chk("nom_gray", 32'(st), 2);
    chk("nom_gstart", 32'(gstart), 1);
    repeat (100) tick();
    pulse_done();
    chk("nom_sync2", 32'(st), 3);
    chk("nom_gstart_sync2", 32'(gstart), 1);
    boundary(1'b0, 1'b0);
    bs_exp++;
    chk("nom_blob", 32'(st), 4);
    chk("nom_gstart_low", 32'(gstart), 0);
    chk("nom_bstart", 32'(bstart), 1);
    tick();
    chk("nom_bstart_1cyc", 32'(bstart), 0);
    pulse_end();
    chk("nom_sync3", 32'(st), 5);
    expect_publish();
    boundary(1'b0, 1'b0);
    chk("nom_rvalid", 32'(rvalid), 1);
    chk("nom_cnt", 32'(fcnt), 1);
    chk("nom_regray", 32'(st), 2);
    chk("nom_regstart", 32'(gstart), 1);

    // Completion coinciding with boundary skips the sync states
    boundary(1'b1, 1'b0);
    bs_exp++;
    chk("sim_blob", 32'(st), 4);
    chk("sim_bstart", 32'(bstart), 1);
    chk("sim_rvalid_clr", 32'(rvalid), 0);
    expect_publish();
    boundary(1'b0, 1'b1);
    chk("sim_publish", 32'(st), 2);
    chk("sim_rvalid", 32'(rvalid), 1);

    // Abort during BLOB still waits for blob_end and publishes
    pulse_done();
    boundary(1'b0, 1'b0);
    bs_exp++;
    ccd = 1'b0;
    tick();
    chk("abort_blob_hold", 32'(st), 4);
    pulse_end();
    chk("abort_sync3", 32'(st), 5);
    expect_publish();
    boundary(1'b0, 1'b0);
    chk("abort_idle", 32'(st), 0);
    chk("abort_gstart", 32'(gstart), 0);
    tick();
    chk("idle_rvalid_held", 32'(rvalid), 1);

    // Abort during GRAY
    ccd = 1'b1;
    tick();
    pulse_done();
    chk("ignored_done", 32'(st), 1);
    boundary(1'b0, 1'b0);
    ccd = 1'b0;
    tick();
    chk("abortg_idle", 32'(st), 0);
    chk("abortg_gstart", 32'(gstart), 0);

    // Two more frames: count wraps 3 -> 0 -> 1
    ccd = 1'b1;
    tick();
    boundary(1'b0, 1'b0);
    boundary(1'b1, 1'b0);
    bs_exp++;
    expect_publish();
    boundary(1'b0, 1'b1);
    chk("wrap_cnt0", 32'(fcnt), 0);
    boundary(1'b1, 1'b0);
    bs_exp++;
    expect_publish();
    boundary(1'b0, 1'b1);
    chk("wrap_cnt1", 32'(fcnt), 1);

    // Timeout in GRAY after the fourth boundary without completion
    for (int i = 0; i < 3; i++) boundary(1'b0, 1'b0);
    chk("to_still_gray", 32'(st), 2);
    boundary(1'b0, 1'b0);
    chk("to_err_state", 32'(st), 6);
    chk("to_err_flag", 32'(err), 1);
    chk("to_gstart", 32'(gstart), 0);
    tick();
    chk("to_err_sticky", 32'(err), 1);
    en = 1'b0;
    tick();
    chk("to_clear_state", 32'(st), 0);
    chk("to_clear_err", 32'(err), 0);

    // Completion on the timeout boundary wins
    en = 1'b1;
    tick();
    boundary(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) boundary(1'b0, 1'b0);
    boundary(1'b1, 1'b0);
    bs_exp++;
    chk("to_win_blob", 32'(st), 4);
    chk("to_win_noerr", 32'(err), 0);

    // Reset mid-BLOB
    tick();
    exp_cnt = '0;
    q.push_back('0);
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(st), 0);
    chk("mrst_bstart", 32'(bstart), 0);
    chk("mrst_rvalid", 32'(rvalid), 0);
    chk("mrst_cnt", 32'(fcnt), 0);
    chk("mrst_gstart", 32'(gstart), 0);
    rst = 1'b0;
    tick(); tick();

    chk("blob_start_count", 32'(bs_seen), 32'(bs_exp));
    chk("sb_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire
